ring_shift_counter: RTL
=======================

RING_SHIFT_COUNTER -- requirements
Module: ring_shift_counter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high: clk is the clock, clear is the reset.
REQ-002 Parameter WIDTH SHALL be 5 by default and is the register length, legal range 2..32.
REQ-003 Parameter SW SHALL default to $clog2(2*WIDTH) and is the step counter width.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port clear  input  1  synchronous active-high reset.
REQ-006 Port en  input  1  advance one shift this cycle.
REQ-007 Port load  input  1  parallel load of ld this cycle.
REQ-008 Port ld  input  WIDTH  parallel load value.
REQ-009 Port mode  input  1  0 = ring (rotate), 1 = Johnson (twisted ring).
REQ-010 Port dir  input  1  0 = shift toward LSB, 1 = shift toward MSB.
REQ-011 Port q  output  WIDTH  registered counter state.
REQ-012 Port step  output  SW  registered count of shifts since the last clear, load or wrap.
REQ-013 Port wrap  output  1  registered one-cycle pulse marking period completion.
REQ-014 Port illegal  output  1  combinational flag: q is not a legal code for the current mode.

Function
REQ-015 Priority at each rising clk edge SHALL be: clear, then load, then en, then hold.
REQ-016 On load, the block SHALL set q=ld, step=0 and wrap=0, ignoring en.
REQ-017 When dir=0 and en=1, q[i] SHALL take q[i+1], and q[WIDTH-1] SHALL take q[0] in ring mode or ~q[0] in Johnson mode.
REQ-018 When dir=1 and en=1, q[i] SHALL take q[i-1], and q[0] SHALL take q[WIDTH-1] in ring mode or ~q[WIDTH-1] in Johnson mode.
REQ-019 The period P SHALL be WIDTH in ring mode and 2*WIDTH in Johnson mode.
REQ-020 On each shift with step >= P-1, the block SHALL set step=0 and wrap=1. On every other shift it SHALL increment step and set wrap=0.
REQ-021 In every non-shift cycle, wrap SHALL be 0 and step SHALL hold, so wrap is high for exactly one cycle.
REQ-022 mode and dir SHALL be sampled every cycle. A change between shifts SHALL take effect on the next shift, and REQ-020 then bounds step.
REQ-023 In ring mode, illegal SHALL be 1 iff popcount(q) != 1.
REQ-024 In Johnson mode, illegal SHALL be 1 iff more than one adjacent pair (q[i], q[i+1]) differs.
REQ-025 All outputs except illegal SHALL be register outputs, with no combinational path from inputs to q, step or wrap.

Reset
REQ-026 clear=1 SHALL set q=0, step=0 and wrap=0 at the next rising edge, overriding load and en.
REQ-027 Assertion of clear mid-period SHALL abandon the period without a wrap pulse.
REQ-028 After reset in ring mode, q=0 is illegal (illegal=1) until a load, except as changed by REQ-030.

Configuration
REQ-029 Macro RING_SHIFT_COUNTER_SELFCORRECT_EN SHALL select the self-correction feature.
REQ-030 With RING_SHIFT_COUNTER_SELFCORRECT_EN defined, a cycle with en=1, load=0 and illegal=1 SHALL replace the shift with: q=1 (one-hot LSB) in ring mode or q=0 in Johnson mode, step=0 and wrap=0.
REQ-031 Without RING_SHIFT_COUNTER_SELFCORRECT_EN, illegal states SHALL shift per REQ-017/018 and only the illegal flag SHALL report them.

Verification (WIDTH=5)
REQ-032 Ring, dir=0: clear, load 00001, then 5 en cycles -> q=10000, 01000, 00100, 00010, 00001; step=1, 2, 3, 4, 0; wrap=1 only after the 5th shift.
REQ-033 Johnson, dir=0: from clear, 10 en cycles -> q=10000, 11000, 11100, 11110, 11111, 01111, 00111, 00011, 00001, 00000; wrap pulses once after the 10th shift; illegal=0 throughout.
REQ-034 Ring, dir=1: load 10000, then 2 en cycles -> q=00001, then 00010; step=2; wrap=0.
REQ-035 Ring: load 11011 -> illegal=1. Then one en cycle -> q=11101 without the macro, or q=00001 with step=0 with the macro.
REQ-036 Simultaneous events: clear=load=en=1 -> q=0, step=0. Then load=en=1 with ld=00100 -> q=00100, step=0, no shift.
REQ-037 Mid-period reset: in Johnson mode, step=7, assert clear -> q=0, step=0; no wrap pulse is ever emitted for the abandoned period.

Source files
------------

// File: rtl/ring_shift_counter.sv
// Ring / Johnson shift counter with a period step counter, wrap pulse and illegal-code flag.
// Optional RING_SHIFT_COUNTER_SELFCORRECT_EN: an enabled shift from an illegal code reseeds instead.
module ring_shift_counter #(
    parameter int WIDTH = 5,
    parameter int SW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] ld,
    input  logic             mode,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic [SW-1:0]    step,
    output logic             wrap,
    output logic             illegal
);

    localparam logic [SW-1:0] RING_LAST = SW'(WIDTH - 1);
    localparam logic [SW-1:0] JOHN_LAST = SW'(2 * WIDTH - 1);

    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-2:0] edges;
    logic             at_last;
    logic             correct;
    logic [WIDTH-1:0] q_nxt;
    logic [SW-1:0]    step_nxt;
    logic             wrap_nxt;

    // Johnson mode inverts the bit that wraps around the end of the register.
    always_comb begin
        if (dir) begin
            fb      = mode ? ~q[WIDTH-1] : q[WIDTH-1];
            shifted = {q[WIDTH-2:0], fb};
        end else begin
            fb      = mode ? ~q[0] : q[0];
            shifted = {fb, q[WIDTH-1:1]};
        end
    end

    assign edges   = q[WIDTH-1:1] ^ q[WIDTH-2:0];
    assign illegal = mode ? ($countones(edges) > 1) : ($countones(q) != 1);
    assign at_last = step >= (mode ? JOHN_LAST : RING_LAST);

`ifdef RING_SHIFT_COUNTER_SELFCORRECT_EN
    assign correct = en & illegal;
`else
    assign correct = 1'b0;
`endif

    always_comb begin
        q_nxt    = q;
        step_nxt = step;
        wrap_nxt = 1'b0;
        if (load) begin
            q_nxt    = ld;
            step_nxt = '0;
        end else if (correct) begin
            q_nxt    = mode ? '0 : WIDTH'(1);
            step_nxt = '0;
        end else if (en) begin
            q_nxt = shifted;
            if (at_last) begin
                step_nxt = '0;
                wrap_nxt = 1'b1;
            end else begin
                step_nxt = step + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q    <= '0;
            step <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            step <= step_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule
